breakout_fsm: RTL

Parametrised game-control state machine for the Breakout top level. It turns keypad/PS2 key events and the graph unit's `hit`/`miss` strobes into game state, a freeze control for the graph (`gra_still`), a remaining-ball count and a BCD score for the seven-segment display. It adds configurable lives, score width, start/pause keys, timed new-ball and game-over phases, and pause.

---
 rtl/breakout_fsm.sv | 134 +++++++++++++
 1 files changed

// File: rtl/breakout_fsm.sv
// Game-control state machine for Breakout: turns key, hit and miss edges into
// game state, graph freeze, remaining balls and a saturating BCD score.
module breakout_fsm #(
  parameter int         LIVES         = 3,
  parameter int         SCORE_DIGITS  = 4,
  parameter logic [4:0] START_KEY     = 5'h10,
  parameter logic [4:0] PAUSE_KEY     = 5'h12,
  parameter int         NEWBALL_DELAY = 50_000_000,
  parameter int         OVER_DELAY    = 200_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                key_code,
  input  logic                      key_ready,
  input  logic                      hit,
  input  logic                      miss,
  output logic [1:0]                state,
  output logic                      gra_still,
  output logic                      paused,
  output logic [3:0]                balls,
  output logic [4*SCORE_DIGITS-1:0] score
);

  localparam logic [1:0] S_NEWGAME = 2'b00;
  localparam logic [1:0] S_PLAY    = 2'b01;
  localparam logic [1:0] S_NEWBALL = 2'b10;
  localparam logic [1:0] S_OVER    = 2'b11;

  localparam int MAX_DELAY = (NEWBALL_DELAY > OVER_DELAY) ? NEWBALL_DELAY : OVER_DELAY;
  localparam int TW        = $clog2(MAX_DELAY + 1);
  localparam int SW        = 4 * SCORE_DIGITS;

  logic          key_ready_d, hit_d, miss_d;
  logic [TW-1:0] timer;
  logic          key_ev, hit_ev, miss_ev, kstart, kpause, tdone;

  logic [1:0]    state_n;
  logic          paused_n, gra_still_n;
  logic [3:0]    balls_n;
  logic [SW-1:0] score_n, score_inc;
  logic [TW-1:0] timer_n;
  logic          all_nines;

  assign key_ev  = key_ready & ~key_ready_d;
  assign hit_ev  = hit & ~hit_d;
  assign miss_ev = miss & ~miss_d;
  assign kstart  = key_ev && (key_code == START_KEY);
  assign kpause  = key_ev && (key_code == PAUSE_KEY);
  assign tdone   = (timer == '0);

  // Ripple-carry BCD increment; a carry surviving the top digit means every digit was 9.
  always_comb begin
    score_inc = score;
    all_nines = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (all_nines) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          all_nines = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n  = state;
    paused_n = paused;
    balls_n  = balls;
    score_n  = score;
    timer_n  = tdone ? timer : timer - TW'(1);
    case (state)
      S_NEWGAME: begin
        if (kstart) begin
          state_n  = S_PLAY;
          score_n  = '0;
          balls_n  = 4'(LIVES);
          paused_n = 1'b0;
        end
      end
      S_PLAY: begin
        if (kpause) paused_n = ~paused;
        if (!paused) begin
          if (hit_ev && !all_nines) score_n = score_inc;
          if (miss_ev) begin
            balls_n  = balls - 4'd1;
            paused_n = 1'b0;
            if (balls == 4'd1) begin
              state_n = S_OVER;
              timer_n = TW'(OVER_DELAY - 1);
            end else begin
              state_n = S_NEWBALL;
              timer_n = TW'(NEWBALL_DELAY - 1);
            end
          end
        end
      end
      S_NEWBALL: begin
        if (kstart && tdone) state_n = S_PLAY;
      end
      default: begin
        if (tdone) state_n = S_NEWGAME;
      end
    endcase
    // Decoded from next state so the freeze moves on the same edge as state and pause
    gra_still_n = (state_n == S_PLAY) ? paused_n : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_NEWGAME;
      gra_still   <= 1'b1;
      paused      <= 1'b0;
      balls       <= 4'(LIVES);
      score       <= '0;
      timer       <= '0;
      key_ready_d <= 1'b1;
      hit_d       <= 1'b1;
      miss_d      <= 1'b1;
    end else begin
      state       <= state_n;
      gra_still   <= gra_still_n;
      paused      <= paused_n;
      balls       <= balls_n;
      score       <= score_n;
      timer       <= timer_n;
      key_ready_d <= key_ready;
      hit_d       <= hit;
      miss_d      <= miss;
    end
  end

endmodule
